alu_issue: RTL and testbench
============================

ALU_ISSUE -- requirements
Module: alu_issue

Interface
REQ-001 SHALL have parameter RD_W, default 5, destination-register tag width.
REQ-002 SHALL have port clk  input  1  sole clock, all state on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port in_valid  input  1  upstream decode has an op.
REQ-005 SHALL have port in_ready  output  1  block accepts op this cycle.
REQ-006 SHALL have ports in_rs1, in_rs2  input  32 each  operand values.
REQ-007 SHALL have ports in_funct3 input 3, in_funct7 input 7  RV32I R-type function fields.
REQ-008 SHALL have port in_rd  input  RD_W  destination tag.
REQ-009 SHALL have ports alu_a, alu_b output 32, alu_op output 3  drive the ALU.
REQ-010 SHALL have ports alu_result input 32, alu_carry input 1  from the ALU.
REQ-011 SHALL have ports out_valid output 1, out_ready input 1  downstream handshake.
REQ-012 SHALL have ports out_result output 32, out_carry output 1, out_rd output RD_W, out_illegal output 1.
REQ-013 SHALL have port retired  output  32  count of ops delivered downstream.

Function
REQ-014 SHALL transfer an input op on any rising edge with in_valid=1 and in_ready=1; likewise output on out_valid=1 and out_ready=1.
REQ-015 SHALL decode: funct3 000/funct7 0000000 -> alu_op 000 (ADD); 000/0100000 -> 001 (SUB); 111/0000000 -> 010 (AND); 110/0000000 -> 011 (OR); 100/0000000 -> 100 (XOR).
REQ-016 SHALL map any other funct3/funct7 pair to alu_op 111 and set the op's illegal bit.
REQ-017 SHALL hold accepted ops in stage S1 (operands, alu_op, rd, illegal, valid); alu_a/alu_b/alu_op driven combinationally from S1, zero when S1 empty.
REQ-018 SHALL capture alu_result/alu_carry, rd, illegal into output stage S2 when S1 valid and S2 free or draining; latency accept-to-out_valid exactly 2 edges.
REQ-019 SHALL force out_result=0 and out_carry=0 for illegal ops, out_illegal=1.
REQ-020 SHALL sustain one op per cycle with out_ready held 1.
REQ-021 SHALL hold out_* stable while out_valid=1 and out_ready=0; no op dropped or duplicated.
REQ-022 SHALL, when S1 and S2 both full and out_ready=0, deassert in_ready.
REQ-023 SHALL allow simultaneous S2 drain, S1->S2 move and new accept in one cycle.
REQ-024 SHALL increment retired by 1 per output transfer, wrapping 0xFFFFFFFF -> 0.

Reset
REQ-025 SHALL, on rst_n low, immediately clear S1/S2 valid, retired=0, out_result=0, out_carry=0, out_rd=0, out_illegal=0, out_valid=0, alu_a/alu_b=0, alu_op=000.
REQ-026 SHALL discard ops in flight when reset asserts mid-operation; in_ready=1 from first edge after rst_n deasserts.

Configuration
REQ-027 SHALL, with ALU_ISSUE_SKID_EN defined, add a one-entry skid buffer after S2 so in_ready is a register output with no combinational path from out_ready; latency unchanged, up to 3 ops buffered.
REQ-028 SHALL, without ALU_ISSUE_SKID_EN, compute in_ready = !S1_valid || !S2_valid || out_ready combinationally, at most 2 ops buffered.

Verification
REQ-029 SHALL cover: reset, send rs1=5 rs2=7 ADD, out_ready=1 -> 2 edges later out_result=12, out_carry=0, retired=1.
REQ-030 SHALL cover: SUB rs1=3 rs2=5 -> out_result=0xFFFFFFFE, out_carry=1; ADD 0xFFFFFFFF+1 -> result 0, carry 1.
REQ-031 SHALL cover: funct3=001 (SLL) rs1=1 rs2=1 -> alu_op=111, out_result=0, out_carry=0, out_illegal=1.
REQ-032 SHALL cover: out_ready=0, stream 4 ops -> in_ready falls after 2 (3 with ALU_ISSUE_SKID_EN), out_* stable; release -> all delivered in order.
REQ-033 SHALL cover: back-to-back 100 ADDs, out_ready=1 -> one result per cycle, retired=100.
REQ-034 SHALL cover: rst_n low with both stages full -> out_valid=0 immediately, retired=0, no stale result after release.

Source files
------------

// File: rtl/alu_issue.sv
`default_nettype none
// ============================================================================
// Module   : alu_issue
// Brief    : Two-stage issue/retire wrapper around an external RV32I ALU.
//            S1 holds the decoded op and drives the ALU; the ALU result is
//            captured into the output stage S2 and handed off downstream with
//            a valid/ready handshake. Also counts retired ops.
// Options  : ALU_ISSUE_SKID_EN - adds a one-entry skid buffer behind S2 so
//            that in_ready is a flop output, independent of out_ready.
// Revision : 1.0 - initial release
// ============================================================================
module alu_issue #(
  parameter int RD_W = 5
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_rs1,
  input  logic [31:0]     in_rs2,
  input  logic [2:0]      in_funct3,
  input  logic [6:0]      in_funct7,
  input  logic [RD_W-1:0] in_rd,
  output logic [31:0]     alu_a,
  output logic [31:0]     alu_b,
  output logic [2:0]      alu_op,
  input  logic [31:0]     alu_result,
  input  logic            alu_carry,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [31:0]     out_result,
  output logic            out_carry,
  output logic [RD_W-1:0] out_rd,
  output logic            out_illegal,
  output logic [31:0]     retired
);

  localparam logic [2:0] c_op_add = 3'b000;
  localparam logic [2:0] c_op_sub = 3'b001;
  localparam logic [2:0] c_op_and = 3'b010;
  localparam logic [2:0] c_op_or  = 3'b011;
  localparam logic [2:0] c_op_xor = 3'b100;
  localparam logic [2:0] c_op_ill = 3'b111;

  localparam logic [6:0] c_f7_base = 7'b0000000;
  localparam logic [6:0] c_f7_alt  = 7'b0100000;

  // Stage S1: decoded op waiting on the ALU
  logic            r_s1_valid;
  logic [31:0]     r_s1_a;
  logic [31:0]     r_s1_b;
  logic [2:0]      r_s1_op;
  logic [RD_W-1:0] r_s1_rd;
  logic            r_s1_ill;

  // Stage S2: head of the output side, visible on out_*
  logic            r_s2_valid;
  logic [31:0]     r_s2_result;
  logic            r_s2_carry;
  logic [RD_W-1:0] r_s2_rd;
  logic            r_s2_ill;

  logic [31:0]     r_retired;

  logic [2:0]      w_dec_op;
  logic            w_dec_ill;
  logic            w_accept;
  logic            w_push;
  logic            w_drain;
  logic [31:0]     w_new_result;
  logic            w_new_carry;

  // Decode the R-type function fields into an ALU opcode
  always_comb begin
    w_dec_op  = c_op_ill;
    w_dec_ill = 1'b1;
    if (in_funct7 == c_f7_base) begin
      unique case (in_funct3)
        3'b000:  begin w_dec_op = c_op_add; w_dec_ill = 1'b0; end
        3'b111:  begin w_dec_op = c_op_and; w_dec_ill = 1'b0; end
        3'b110:  begin w_dec_op = c_op_or;  w_dec_ill = 1'b0; end
        3'b100:  begin w_dec_op = c_op_xor; w_dec_ill = 1'b0; end
        default: begin w_dec_op = c_op_ill; w_dec_ill = 1'b1; end
      endcase
    end else if (in_funct7 == c_f7_alt && in_funct3 == 3'b000) begin
      w_dec_op  = c_op_sub;
      w_dec_ill = 1'b0;
    end
  end

  // ALU drive comes straight from S1; idle ALU sees zeros
  assign alu_a  = r_s1_valid ? r_s1_a  : 32'd0;
  assign alu_b  = r_s1_valid ? r_s1_b  : 32'd0;
  assign alu_op = r_s1_valid ? r_s1_op : c_op_add;

  // Illegal ops never leak whatever the ALU produced for opcode 111
  assign w_new_result = r_s1_ill ? 32'd0 : alu_result;
  assign w_new_carry  = r_s1_ill ? 1'b0  : alu_carry;

  assign w_drain  = r_s2_valid && out_ready;
  assign w_accept = in_valid && in_ready;

  // S1: load on accept, empty once its op has moved to the output side
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_valid <= 1'b0;
      r_s1_a     <= 32'd0;
      r_s1_b     <= 32'd0;
      r_s1_op    <= c_op_add;
      r_s1_rd    <= '0;
      r_s1_ill   <= 1'b0;
    end else if (w_accept) begin
      r_s1_valid <= 1'b1;
      r_s1_a     <= in_rs1;
      r_s1_b     <= in_rs2;
      r_s1_op    <= w_dec_op;
      r_s1_rd    <= in_rd;
      r_s1_ill   <= w_dec_ill;
    end else if (w_push) begin
      r_s1_valid <= 1'b0;
    end
  end

`ifdef ALU_ISSUE_SKID_EN
  // Skid entry: second slot behind S2, always younger than S2
  logic            r_sk_valid;
  logic [31:0]     r_sk_result;
  logic            r_sk_carry;
  logic [RD_W-1:0] r_sk_rd;
  logic            r_sk_ill;
  logic            r_in_ready;
  logic [2:0]      w_occ;
  logic [2:0]      w_occ_next;

  // S1 may move whenever the two-entry output side has a free slot this cycle
  assign w_push = r_s1_valid && (!r_sk_valid || w_drain);

  assign w_occ      = {2'b00, r_s1_valid} + {2'b00, r_s2_valid} + {2'b00, r_sk_valid};
  assign w_occ_next = w_occ + {2'b00, w_accept} - {2'b00, w_drain};
  assign in_ready   = r_in_ready;

  // Ready for next cycle only if one more op fits even with no drain
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_in_ready <= 1'b1;
    end else begin
      r_in_ready <= (w_occ_next <= 3'd2);
    end
  end

  // Output side as a two-entry FIFO: S2 is the head, skid the tail
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s2_valid  <= 1'b0;
      r_s2_result <= 32'd0;
      r_s2_carry  <= 1'b0;
      r_s2_rd     <= '0;
      r_s2_ill    <= 1'b0;
      r_sk_valid  <= 1'b0;
      r_sk_result <= 32'd0;
      r_sk_carry  <= 1'b0;
      r_sk_rd     <= '0;
      r_sk_ill    <= 1'b0;
    end else if (w_drain) begin
      if (r_sk_valid) begin
        r_s2_result <= r_sk_result;
        r_s2_carry  <= r_sk_carry;
        r_s2_rd     <= r_sk_rd;
        r_s2_ill    <= r_sk_ill;
        r_sk_valid  <= w_push;
        if (w_push) begin
          r_sk_result <= w_new_result;
          r_sk_carry  <= w_new_carry;
          r_sk_rd     <= r_s1_rd;
          r_sk_ill    <= r_s1_ill;
        end
      end else begin
        r_s2_valid <= w_push;
        if (w_push) begin
          r_s2_result <= w_new_result;
          r_s2_carry  <= w_new_carry;
          r_s2_rd     <= r_s1_rd;
          r_s2_ill    <= r_s1_ill;
        end
      end
    end else if (w_push) begin
      if (!r_s2_valid) begin
        r_s2_valid  <= 1'b1;
        r_s2_result <= w_new_result;
        r_s2_carry  <= w_new_carry;
        r_s2_rd     <= r_s1_rd;
        r_s2_ill    <= r_s1_ill;
      end else begin
        r_sk_valid  <= 1'b1;
        r_sk_result <= w_new_result;
        r_sk_carry  <= w_new_carry;
        r_sk_rd     <= r_s1_rd;
        r_sk_ill    <= r_s1_ill;
      end
    end
  end
`else
  // S1 moves when S2 is empty or handing its op off this cycle
  assign w_push   = r_s1_valid && (!r_s2_valid || out_ready);
  assign in_ready = !r_s1_valid || !r_s2_valid || out_ready;

  // S2: capture the ALU result for the S1 op, empty after a handoff
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s2_valid  <= 1'b0;
      r_s2_result <= 32'd0;
      r_s2_carry  <= 1'b0;
      r_s2_rd     <= '0;
      r_s2_ill    <= 1'b0;
    end else if (w_push) begin
      r_s2_valid  <= 1'b1;
      r_s2_result <= w_new_result;
      r_s2_carry  <= w_new_carry;
      r_s2_rd     <= r_s1_rd;
      r_s2_ill    <= r_s1_ill;
    end else if (w_drain) begin
      r_s2_valid <= 1'b0;
    end
  end
`endif

  // Count every downstream handoff; wraps naturally at 2^32
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_retired <= 32'd0;
    end else if (w_drain) begin
      r_retired <= r_retired + 32'd1;
    end
  end

  assign out_valid   = r_s2_valid;
  assign out_result  = r_s2_result;
  assign out_carry   = r_s2_carry;
  assign out_rd      = r_s2_rd;
  assign out_illegal = r_s2_ill;
  assign retired     = r_retired;

endmodule
`default_nettype wire

// File: tb/tb_alu_issue.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_issue
// Brief    : Directed, table-driven bench for alu_issue with a behavioural
//            ALU and an in-order expected-result queue.
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_issue;

  localparam int RD_W = 5;
`ifdef ALU_ISSUE_SKID_EN
  localparam int CAP = 3;
`else
  localparam int CAP = 2;
`endif

  logic            clk;
  logic            rst_n;
  logic            in_valid;
  logic            in_ready;
  logic [31:0]     in_rs1;
  logic [31:0]     in_rs2;
  logic [2:0]      in_funct3;
  logic [6:0]      in_funct7;
  logic [RD_W-1:0] in_rd;
  logic [31:0]     alu_a;
  logic [31:0]     alu_b;
  logic [2:0]      alu_op;
  logic [31:0]     alu_result;
  logic            alu_carry;
  logic            out_valid;
  logic            out_ready;
  logic [31:0]     out_result;
  logic            out_carry;
  logic [RD_W-1:0] out_rd;
  logic            out_illegal;
  logic [31:0]     retired;

  alu_issue #(.RD_W(RD_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_rs1(in_rs1), .in_rs2(in_rs2),
    .in_funct3(in_funct3), .in_funct7(in_funct7), .in_rd(in_rd),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
    .alu_result(alu_result), .alu_carry(alu_carry),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_carry(out_carry),
    .out_rd(out_rd), .out_illegal(out_illegal),
    .retired(retired)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural ALU; opcode 111 returns junk so forcing to zero is visible
  always_comb begin
    alu_result = 32'd0;
    alu_carry  = 1'b0;
    case (alu_op)
      3'b000:  {alu_carry, alu_result} = {1'b0, alu_a} + {1'b0, alu_b};
      3'b001:  {alu_carry, alu_result} = {1'b0, alu_a} - {1'b0, alu_b};
      3'b010:  alu_result = alu_a & alu_b;
      3'b011:  alu_result = alu_a | alu_b;
      3'b100:  alu_result = alu_a ^ alu_b;
      default: begin alu_result = 32'hDEADBEEF; alu_carry = 1'b1; end
    endcase
  end

  typedef struct {
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [2:0]  op;
    logic [31:0] res;
    logic        carry;
    logic        ill;
  } vec_t;

  typedef struct {
    logic [31:0]     res;
    logic            carry;
    logic [RD_W-1:0] rd;
    logic            ill;
  } exp_t;

  vec_t  vecs [10];
  exp_t  q[$];
  exp_t  cur_exp;
  int    n_cmp;
  int    n_bad;
  int    exp_retired;
  bit    last_acc;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One cycle: sample handshakes just after inputs settle, then cross a posedge
  task automatic tick();
    exp_t e;
    #1;
    if (out_valid === 1'b1 && out_ready === 1'b1) begin
      if (q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_output: got rd %0d result %h, expected no output", out_rd, out_result);
      end else begin
        e = q.pop_front();
        chk("out_result", out_result, e.res);
        chk("out_carry", {31'd0, out_carry}, {31'd0, e.carry});
        chk("out_rd", {27'd0, out_rd}, {27'd0, e.rd});
        chk("out_illegal", {31'd0, out_illegal}, {31'd0, e.ill});
        exp_retired++;
      end
    end
    last_acc = (in_valid === 1'b1 && in_ready === 1'b1);
    if (last_acc) q.push_back(cur_exp);
    @(negedge clk);
    chk("retired", retired, 32'(exp_retired));
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    q.delete();
    exp_retired = 0;
    @(negedge clk);
  endtask

  task automatic set_add(input logic [31:0] a, input logic [31:0] b, input int rd);
    in_rs1    = a;
    in_rs2    = b;
    in_funct3 = 3'b000;
    in_funct7 = 7'b0000000;
    in_rd     = RD_W'(rd);
    cur_exp   = '{a + b, 1'b0, RD_W'(rd), 1'b0};
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    int sent;
    int nt;
    int miss;
    logic [31:0] snap_res;
    logic [RD_W-1:0] snap_rd;

    n_cmp = 0; n_bad = 0; exp_retired = 0; last_acc = 1'b0;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    in_rs1 = '0; in_rs2 = '0; in_funct3 = '0; in_funct7 = '0; in_rd = '0;
    cur_exp = '{32'd0, 1'b0, '0, 1'b0};

    vecs[0] = '{32'd5,        32'd7,        3'b000, 7'b0000000, 3'b000, 32'd12,       1'b0, 1'b0};
    vecs[1] = '{32'd3,        32'd5,        3'b000, 7'b0100000, 3'b001, 32'hFFFFFFFE, 1'b1, 1'b0};
    vecs[2] = '{32'hFFFFFFFF, 32'd1,        3'b000, 7'b0000000, 3'b000, 32'd0,        1'b1, 1'b0};
    vecs[3] = '{32'd1,        32'd1,        3'b001, 7'b0000000, 3'b111, 32'd0,        1'b0, 1'b1};
    vecs[4] = '{32'hF0F0F0F0, 32'hFF00FF00, 3'b111, 7'b0000000, 3'b010, 32'hF000F000, 1'b0, 1'b0};
    vecs[5] = '{32'h000000F0, 32'h0000000F, 3'b110, 7'b0000000, 3'b011, 32'h000000FF, 1'b0, 1'b0};
    vecs[6] = '{32'hAAAA5555, 32'hFFFF0000, 3'b100, 7'b0000000, 3'b100, 32'h55555555, 1'b0, 1'b0};
    vecs[7] = '{32'd6,        32'd7,        3'b000, 7'b0000001, 3'b111, 32'd0,        1'b0, 1'b1};
    vecs[8] = '{32'd10,       32'd3,        3'b000, 7'b0100000, 3'b001, 32'd7,        1'b0, 1'b0};
    vecs[9] = '{32'd3,        32'd3,        3'b111, 7'b0100000, 3'b111, 32'd0,        1'b0, 1'b1};

    // Reset state, sampled while reset is held
    repeat (2) @(negedge clk);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_retired", retired, 32'd0);
    chk("rst_out_result", out_result, 32'd0);
    chk("rst_out_carry", {31'd0, out_carry}, 32'd0);
    chk("rst_out_rd", {27'd0, out_rd}, 32'd0);
    chk("rst_out_illegal", {31'd0, out_illegal}, 32'd0);
    chk("rst_alu_a", alu_a, 32'd0);
    chk("rst_alu_b", alu_b, 32'd0);
    chk("rst_alu_op", {29'd0, alu_op}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_in_ready", {31'd0, in_ready}, 32'd1);

    // Table: one op at a time, check decode, ALU drive and 2-edge latency
    for (int i = 0; i < 10; i++) begin
      in_rs1    = vecs[i].rs1;
      in_rs2    = vecs[i].rs2;
      in_funct3 = vecs[i].f3;
      in_funct7 = vecs[i].f7;
      in_rd     = RD_W'(i);
      cur_exp   = '{vecs[i].res, vecs[i].carry, RD_W'(i), vecs[i].ill};
      in_valid  = 1'b1;
      tick();
      chk("vec_accept", {31'd0, last_acc}, 32'd1);
      in_valid = 1'b0;
      chk("vec_alu_op", {29'd0, alu_op}, {29'd0, vecs[i].op});
      chk("vec_alu_a", alu_a, vecs[i].rs1);
      chk("vec_alu_b", alu_b, vecs[i].rs2);
      chk("lat_edge1_out_valid", {31'd0, out_valid}, 32'd0);
      tick();
      chk("lat_edge2_out_valid", {31'd0, out_valid}, 32'd1);
      tick();
      if (i == 0) chk("first_retired", retired, 32'd1);
    end
    chk("table_drained", 32'(q.size()), 32'd0);

    // Backpressure: stream 4 ops with out_ready low
    do_reset();
    out_ready = 1'b0;
    sent = 0;
    for (int c = 0; c < 6; c++) begin
      set_add(32'(10 * sent), 32'd1, 20 + sent);
      in_valid = 1'b1;
      tick();
      if (last_acc) sent++;
    end
    chk("bp_accepted", 32'(sent), 32'(CAP));
    chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
    chk("bp_out_valid", {31'd0, out_valid}, 32'd1);
    chk("bp_head_result", out_result, 32'd1);
    snap_res = out_result;
    snap_rd  = out_rd;
    repeat (3) begin
      tick();
      if (last_acc) sent++;
    end
    chk("bp_hold_result", out_result, snap_res);
    chk("bp_hold_rd", {27'd0, out_rd}, {27'd0, snap_rd});
    chk("bp_hold_accepted", 32'(sent), 32'(CAP));
    out_ready = 1'b1;
    for (int c = 0; c < 20; c++) begin
      if (sent < 4) begin
        set_add(32'(10 * sent), 32'd1, 20 + sent);
        in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      tick();
      if (last_acc) sent++;
      if (sent == 4 && q.size() == 0) break;
    end
    in_valid = 1'b0;
    chk("bp_all_sent", 32'(sent), 32'd4);
    chk("bp_all_delivered", 32'(q.size()), 32'd0);
    chk("bp_retired", retired, 32'd4);

    // Back-to-back: 100 ADDs, one per cycle
    do_reset();
    out_ready = 1'b1;
    nt = 0;
    miss = 0;
    for (int i = 0; i < 100; i++) begin
      set_add(32'(i), 32'(2 * i), i);
      in_valid = 1'b1;
      tick();
      nt++;
      if (!last_acc) miss++;
    end
    in_valid = 1'b0;
    for (int k = 0; k < 10; k++) begin
      if (q.size() != 0) begin
        tick();
        nt++;
      end
    end
    chk("b2b_stalls", 32'(miss), 32'd0);
    chk("b2b_cycles", 32'(nt), 32'd102);
    chk("b2b_drained", 32'(q.size()), 32'd0);
    chk("b2b_retired", retired, 32'd100);

    // Reset with both stages full
    out_ready = 1'b0;
    sent = 0;
    for (int c = 0; c < 2; c++) begin
      set_add(32'(c + 1), 32'd100, c);
      in_valid = 1'b1;
      tick();
      if (last_acc) sent++;
    end
    in_valid = 1'b0;
    chk("rstfull_sent", 32'(sent), 32'd2);
    chk("rstfull_pre_valid", {31'd0, out_valid}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rstfull_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rstfull_retired", retired, 32'd0);
    chk("rstfull_out_result", out_result, 32'd0);
    chk("rstfull_alu_a", alu_a, 32'd0);
    chk("rstfull_out_rd", {27'd0, out_rd}, 32'd0);
    q.delete();
    exp_retired = 0;
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    tick();
    chk("rstfull_in_ready", {31'd0, in_ready}, 32'd1);
    repeat (3) tick();
    chk("rstfull_no_stale", {31'd0, out_valid}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
